// File: rtl/e203_tb_cmt_monitor_pkg.sv
// Shared constants for the end-of-test commit monitor: state codes,
// default tohost addresses and counter widths.
package e203_tb_mon_pkg;

  localparam int unsigned STATE_W      = 3;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned TOHOST_CNT_W = 8;

  localparam logic [STATE_W-1:0] ST_RUN     = 3'd0;
  localparam logic [STATE_W-1:0] ST_DRAIN   = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE  = 3'd2;
  localparam logic [STATE_W-1:0] ST_DONE    = 3'd3;
  localparam logic [STATE_W-1:0] ST_TIMEOUT = 3'd4;

  localparam logic [31:0] PC_TOHOST_DEF         = 32'h8000_0086;
  localparam logic [31:0] PC_AFTER_SETMTVEC_DEF = 32'h8000_009c;

  // DONE and TIMEOUT hold until reset; every counter freezes there
  function automatic logic is_terminal(input logic [STATE_W-1:0] s);
    return (s == ST_DONE) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/e203_tb_cmt_monitor_if.sv
// Commit/dispatch stream observed by the end-of-test monitor.
interface e203_tb_cmt_monitor_if #(
  parameter int unsigned PC_W = 32,
  parameter int unsigned XLEN = 32
);
  logic            cmt_valid;
  logic [PC_W-1:0] cmt_pc;
  logic            exu_i_valid;
  logic            exu_i_ready;
  logic [XLEN-1:0] x3;
  logic            irq_busy;

  modport master (
    output cmt_valid, cmt_pc, exu_i_valid, exu_i_ready, x3, irq_busy
  );

  modport slave (
    input cmt_valid, cmt_pc, exu_i_valid, exu_i_ready, x3, irq_busy
  );
endinterface

// File: rtl/e203_tb_sat_cnt.sv
// Saturating up-counter with synchronous active-high clear.
module e203_tb_sat_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/e203_tb_cmt_monitor.sv
// End-of-test monitor: counts cycles/instructions, waits for tohost commits
// and IRQ drain, then samples x3 to decide pass/fail or declares timeout.
module e203_tb_cmt_monitor
  import e203_tb_mon_pkg::*;
#(
  parameter int unsigned     PC_W        = 32,
  parameter int unsigned     XLEN        = 32,
  parameter logic [PC_W-1:0] PC_TOHOST   = PC_W'(PC_TOHOST_DEF),
  parameter int unsigned     TOHOST_HITS = 8,
  parameter int unsigned     SETTLE_CYC  = 3,
  parameter int unsigned     TIMEOUT_CYC = 10000000
) (
  input  logic                    clk,
  input  logic                    rst,
  e203_tb_cmt_monitor_if.slave    cmt,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [CNT_W-1:0]        cycle_cnt,
  output logic [CNT_W-1:0]        instr_cnt,
  output logic [CNT_W-1:0]        end_cycle,
  output logic [TOHOST_CNT_W-1:0] tohost_cnt,
  output logic [STATE_W-1:0]      state
);

  localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  logic                    terminal_c;
  logic                    hit_c;
  logic                    first_hit_c;
  logic                    timeout_hit_c;
  logic                    dispatch_c;

  logic [STATE_W-1:0]      state_nxt;
  logic [SETTLE_W-1:0]     settle_cnt;
  logic [SETTLE_W-1:0]     settle_nxt;
  logic                    done_nxt;
  logic                    pass_nxt;
  logic                    timeout_nxt;
  logic [CNT_W-1:0]        end_cycle_nxt;

  // Qualifiers; tohost_cnt==0 means no hit yet since it never wraps
  assign terminal_c    = is_terminal(state);
  assign hit_c         = cmt.cmt_valid && (cmt.cmt_pc == PC_TOHOST);
  assign first_hit_c   = hit_c && (tohost_cnt == '0) && !terminal_c;
  assign timeout_hit_c = (cycle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign dispatch_c    = cmt.exu_i_valid && cmt.exu_i_ready;

  e203_tb_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!terminal_c),
    .q   (cycle_cnt)
  );

  e203_tb_sat_cnt #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .inc (dispatch_c && (tohost_cnt == '0) && !terminal_c),
    .q   (instr_cnt)
  );

  e203_tb_sat_cnt #(.W(TOHOST_CNT_W)) u_tohost_cnt (
    .clk (clk),
    .rst (rst),
    .inc (hit_c && !terminal_c),
    .q   (tohost_cnt)
  );

  // Next-state and registered-output next values
  always_comb begin
    state_nxt     = state;
    settle_nxt    = settle_cnt;
    done_nxt      = done;
    pass_nxt      = pass;
    timeout_nxt   = timeout;
    end_cycle_nxt = end_cycle;

    if (first_hit_c) begin
      end_cycle_nxt = cycle_cnt;
    end

    case (state)
      ST_RUN: begin
        if (hit_c && (tohost_cnt == TOHOST_CNT_W'(TOHOST_HITS - 1))) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!cmt.irq_busy) begin
          state_nxt  = ST_SETTLE;
          settle_nxt = SETTLE_W'(SETTLE_CYC - 1);
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == '0) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          pass_nxt  = (cmt.x3 == XLEN'(1));
        end else begin
          settle_nxt = settle_cnt - SETTLE_W'(1);
        end
      end
      default: begin
      end
    endcase

    // A simultaneous SETTLE->DONE completion takes priority over the budget
    if (!terminal_c && timeout_hit_c && (state_nxt != ST_DONE)) begin
      state_nxt   = ST_TIMEOUT;
      done_nxt    = 1'b1;
      timeout_nxt = 1'b1;
      pass_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      settle_cnt <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      end_cycle  <= '0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      timeout    <= timeout_nxt;
      end_cycle  <= end_cycle_nxt;
    end
  end

endmodule
